// File: rtl/mcu_core_param.sv
// rtl/mcu_core_param.sv - parametrised multi-cycle accumulator core with program loader and call stack
// Every instruction takes FETCH, DECODE and EXECUTE; program and data memories are internal.
module mcu_core_param #(
   parameter  int DW          = 8,
   parameter  int PAW         = 8,
   parameter  int DAW         = 4,
   parameter  int STACK_DEPTH = 4,
   localparam int IW          = DW + 8,
   localparam int SPW         = $clog2(STACK_DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ld_valid,
   input  logic [IW-1:0]  ld_data,
   input  logic           ld_last,
   output logic           ld_ready,
   output logic           halted,
   output logic           error,
   output logic [1:0]     err_code,
   output logic [PAW-1:0] pc_out,
   output logic [DW-1:0]  acc_out,
   output logic [3:0]     flags_out,
   output logic [SPW-1:0] sp_out
);
   localparam int M   = DW - 1;
   localparam int SHW = $clog2(DW);
   localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [PAW-1:0] PC_ONE = PAW'(1);
   localparam logic [SPW-1:0] SP_ONE = SPW'(1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
   localparam logic [DW-1:0]  D_ONE  = DW'(1);
   localparam logic [DW-1:0]  D_ZERO = '0;

   localparam logic [3:0] C_NOP  = 4'h0;
   localparam logic [3:0] C_HALT = 4'h1;
   localparam logic [3:0] C_JMP  = 4'h2;
   localparam logic [3:0] C_JCND = 4'h3;
   localparam logic [3:0] C_CALL = 4'h4;
   localparam logic [3:0] C_RET  = 4'h5;
   localparam logic [3:0] C_ALUI = 4'h6;
   localparam logic [3:0] C_ALUM = 4'h7;
   localparam logic [3:0] C_ALUW = 4'h8;
   localparam logic [3:0] C_STA  = 4'hA;

   typedef enum logic [2:0] {
      S_LOAD   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t r_state, w_state_nxt;

   logic [IW-1:0]  r_pmem  [2**PAW];
   logic [DW-1:0]  r_dmem  [2**DAW];
   logic [PAW-1:0] r_stack [STACK_DEPTH];

   logic [IW-1:0]  r_ir;
   logic [DW-1:0]  r_dr;
   logic [PAW-1:0] r_pc;
   logic [DW-1:0]  r_acc;
   logic           r_z, r_c, r_s, r_o;
   logic [SPW-1:0] r_sp;
   logic [PAW-1:0] r_ptr;
   logic           r_error;
   logic [1:0]     r_err_code;

   logic [3:0]     w_class, w_mode;
   logic [DW-1:0]  w_opnd;
   logic [PAW-1:0] w_target, w_pc_inc, w_pc_nxt;
   logic [DAW-1:0] w_addr;
   logic [SHW-1:0] w_shamt;
   logic [3:0]     w_flag_vec;
   logic           w_flag_sel, w_ld_acc;

   logic [DW-1:0]   w_alu_b, w_alu_res;
   logic [DW:0]     w_sum;
   logic [2*DW-1:0] w_rot2, w_rol2, w_ror2;
   logic            w_alu_c, w_alu_o;

   logic           w_acc_we, w_flag_we, w_dmem_we, w_push, w_pop, w_fault;
   logic [DW-1:0]  w_dmem_wdata;
   logic [1:0]     w_fault_code;

   assign w_class    = r_ir[IW-1:IW-4];
   assign w_mode     = r_ir[IW-5:IW-8];
   assign w_opnd     = r_ir[DW-1:0];
   assign w_target   = w_opnd[PAW-1:0];
   assign w_addr     = w_opnd[DAW-1:0];
   assign w_shamt    = r_acc[SHW-1:0];
   assign w_pc_inc   = r_pc + PC_ONE;
   assign w_flag_vec = {r_o, r_s, r_c, r_z};
   assign w_flag_sel = w_flag_vec[w_mode[1:0]];
   assign w_ld_acc   = (r_state == S_LOAD) && ld_valid;

   // Carry on subtract-class modes is "no borrow", i.e. minuend >= subtrahend.
   always_comb begin
      w_alu_b   = (w_class == C_ALUI) ? w_opnd : r_dr;
      w_rot2    = {w_alu_b, w_alu_b};
      w_rol2    = w_rot2 << w_shamt;
      w_ror2    = w_rot2 >> w_shamt;
      w_sum     = '0;
      w_alu_res = '0;
      w_alu_c   = r_c;
      w_alu_o   = 1'b0;
      case (w_mode)
         4'h0: begin
            w_sum     = {1'b0, r_acc} + {1'b0, w_alu_b};
            w_alu_res = w_sum[DW-1:0];
            w_alu_c   = w_sum[DW];
            w_alu_o   = (r_acc[M] == w_alu_b[M]) && (w_alu_res[M] != r_acc[M]);
         end
         4'h1: begin
            w_alu_res = r_acc - w_alu_b;
            w_alu_c   = (r_acc >= w_alu_b);
            w_alu_o   = (r_acc[M] != w_alu_b[M]) && (w_alu_res[M] != r_acc[M]);
         end
         4'h2: w_alu_res = r_acc;
         4'h3: w_alu_res = w_alu_b;
         4'h4: w_alu_res = r_acc & w_alu_b;
         4'h5: w_alu_res = r_acc | w_alu_b;
         4'h6: w_alu_res = r_acc ^ w_alu_b;
         4'h7: begin
            w_alu_res = w_alu_b - r_acc;
            w_alu_c   = (w_alu_b >= r_acc);
            w_alu_o   = (w_alu_b[M] != r_acc[M]) && (w_alu_res[M] != w_alu_b[M]);
         end
         4'h8: begin
            w_sum     = {1'b0, w_alu_b} + {1'b0, D_ONE};
            w_alu_res = w_sum[DW-1:0];
            w_alu_c   = w_sum[DW];
            w_alu_o   = !w_alu_b[M] && w_alu_res[M];
         end
         4'h9: begin
            w_alu_res = w_alu_b - D_ONE;
            w_alu_c   = (w_alu_b != D_ZERO);
            w_alu_o   = w_alu_b[M] && !w_alu_res[M];
         end
         4'hA: w_alu_res = w_rol2[2*DW-1:DW];
         4'hB: w_alu_res = w_ror2[DW-1:0];
         4'hC: w_alu_res = w_alu_b << w_shamt;
         4'hD: w_alu_res = w_alu_b >> w_shamt;
         4'hE: w_alu_res = $signed(w_alu_b) >>> w_shamt;
         default: begin
            w_alu_res = D_ZERO - w_alu_b;
            w_alu_c   = (w_alu_b == D_ZERO);
            w_alu_o   = w_alu_b[M] && w_alu_res[M];
         end
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_acc_we     = 1'b0;
      w_flag_we    = 1'b0;
      w_dmem_we    = 1'b0;
      w_dmem_wdata = r_acc;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_fault      = 1'b0;
      w_fault_code = 2'd0;
      case (r_state)
         S_LOAD: begin
            if (w_ld_acc && (ld_last || (r_ptr == '1)))
               w_state_nxt = S_FETCH;
         end
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = S_EXEC;
         S_EXEC: begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = w_pc_inc;
            case (w_class)
               C_NOP: ;
               C_HALT: begin
                  w_state_nxt = S_HALT;
                  w_pc_nxt    = r_pc;
               end
               C_JMP:  w_pc_nxt = w_target;
               C_JCND: begin
                  if (w_flag_sel ^ w_mode[2])
                     w_pc_nxt = w_target;
               end
               C_CALL: begin
                  if (r_sp == SP_FULL) begin
                     w_state_nxt  = S_HALT;
                     w_pc_nxt     = r_pc;
                     w_fault      = 1'b1;
                     w_fault_code = 2'd1;
                  end else begin
                     w_push   = 1'b1;
                     w_pc_nxt = w_target;
                  end
               end
               C_RET: begin
                  if (r_sp == '0) begin
                     w_state_nxt  = S_HALT;
                     w_pc_nxt     = r_pc;
                     w_fault      = 1'b1;
                     w_fault_code = 2'd2;
                  end else begin
                     w_pop    = 1'b1;
                     w_pc_nxt = r_stack[SIW'(r_sp - SP_ONE)];
                  end
               end
               C_ALUI, C_ALUM: begin
                  w_acc_we  = 1'b1;
                  w_flag_we = 1'b1;
               end
               C_ALUW: begin
                  w_dmem_we    = 1'b1;
                  w_dmem_wdata = w_alu_res;
                  w_flag_we    = 1'b1;
               end
               C_STA: w_dmem_we = 1'b1;
               default: begin
                  w_state_nxt  = S_HALT;
                  w_pc_nxt     = r_pc;
                  w_fault      = 1'b1;
                  w_fault_code = 2'd3;
               end
            endcase
         end
         default: w_state_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_LOAD;
      else
         r_state <= w_state_nxt;
   end

   // Storage is never cleared; writes are suppressed on a reset edge.
   always_ff @(posedge clk) begin
      if (!rst && w_ld_acc)
         r_pmem[r_ptr] <= ld_data;
      if (!rst && w_dmem_we)
         r_dmem[w_addr] <= w_dmem_wdata;
      if (!rst && w_push)
         r_stack[SIW'(r_sp)] <= w_pc_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= '0;
         r_acc      <= '0;
         r_z        <= 1'b0;
         r_c        <= 1'b0;
         r_s        <= 1'b0;
         r_o        <= 1'b0;
         r_sp       <= '0;
         r_ptr      <= '0;
         r_ir       <= '0;
         r_dr       <= '0;
         r_error    <= 1'b0;
         r_err_code <= 2'd0;
      end else begin
         if (w_ld_acc) begin
            r_ptr <= r_ptr + PC_ONE;
            if (w_state_nxt == S_FETCH) begin
               r_pc  <= '0;
               r_acc <= '0;
               r_z   <= 1'b0;
               r_c   <= 1'b0;
               r_s   <= 1'b0;
               r_o   <= 1'b0;
               r_sp  <= '0;
            end
         end
         if (r_state == S_FETCH)
            r_ir <= r_pmem[r_pc];
         if (r_state == S_DECODE)
            r_dr <= r_dmem[w_addr];
         if (r_state == S_EXEC)
            r_pc <= w_pc_nxt;
         if (w_acc_we)
            r_acc <= w_alu_res;
         if (w_flag_we) begin
            r_z <= (w_alu_res == D_ZERO);
            r_c <= w_alu_c;
            r_s <= w_alu_res[M];
            r_o <= w_alu_o;
         end
         if (w_push)
            r_sp <= r_sp + SP_ONE;
         if (w_pop)
            r_sp <= r_sp - SP_ONE;
         if (w_fault) begin
            r_error    <= 1'b1;
            r_err_code <= w_fault_code;
         end
      end
   end

   assign ld_ready  = (r_state == S_LOAD);
   assign halted    = (r_state == S_HALT);
   assign error     = r_error;
   assign err_code  = r_err_code;
   assign pc_out    = r_pc;
   assign acc_out   = r_acc;
   assign flags_out = {r_z, r_c, r_s, r_o};
   assign sp_out    = r_sp;

endmodule

// File: doc/mcu_core_param.md
Name: mcu_core_param

Overview:
- Parametrised successor to the team's 12-bit accumulator microcontroller.
- Multi-cycle accumulator core with data width, program/data address widths and call-stack depth set by parameters.
- Adds a ready/valid program-load port, a hardware CALL/RET stack, conditional jumps with polarity select, and a HALT state with error reporting.
- Sits as the CPU tile driven by the test harness or a boot loader; program and data memories are internal.

Parameters:
DW, 8, data/accumulator width; power of 2, >=4
PAW, 8, program address width; PAW <= DW; program memory depth = 2**PAW
DAW, 4, data address width; DAW <= DW; data memory depth = 2**DAW
STACK_DEPTH, 4, return-stack entries (>=1)
IW, DW+8 (derived, not overridable), instruction width: class[IW-1:IW-4], mode[IW-5:IW-8], operand[DW-1:0]

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ld_valid  in  1  program word valid
ld_data  in  IW  program word
ld_last  in  1  final word of program (qualified by ld_valid)
ld_ready  out  1  core accepts a program word (high only in LOAD)
halted  out  1  core in HALT state
error  out  1  halt caused by a fault
err_code  out  2  0 none, 1 stack overflow, 2 stack underflow, 3 illegal opcode
pc_out  out  PAW  current PC
acc_out  out  DW  accumulator
flags_out  out  4  {Z,C,S,O}
sp_out  out  clog2(STACK_DEPTH+1)  stack occupancy

Behaviour:
- Reset values (next edge with rst=1; wins over everything): state=LOAD; PC=0; Acc=0; flags=0; SP=0; load pointer=0; halted=0; error=0; err_code=0; ld_ready=1 in the following cycle. Memory contents are not cleared.
- States: LOAD, FETCH, DECODE, EXECUTE, HALT.
- LOAD: every cycle with ld_valid&ld_ready, PMEM[ptr]<=ld_data and ptr++. If ld_last is set or ptr==2**PAW-1 on the accepted word, the next state is FETCH with PC/Acc/flags/SP cleared. Gaps in ld_valid are legal.
- FETCH: IR<=PMEM[PC].
- DECODE: DR<=DMEM[operand[DAW-1:0]] (synchronous read).
- EXECUTE: commits the instruction, then returns to FETCH. Each instruction is exactly 3 cycles.
- PC increment wraps modulo 2**PAW.
- Classes (hex) and their EXECUTE action:
  - 0 NOP: PC+1.
  - 1 HALT: go to HALT; PC is unchanged; error=0.
  - 2 JMP: PC<=operand[PAW-1:0].
  - 3 JCOND: taken if flag[mode[1:0]] XOR mode[2] is 1. mode[1:0] selects 0=Z, 1=C, 2=S, 3=O. Taken: PC<=target; not taken: PC+1.
  - 4 CALL: if SP==STACK_DEPTH, HALT with err 1 and PC unchanged. Else stack[SP]<=PC+1, SP++, PC<=target.
  - 5 RET: if SP==0, HALT with err 2. Else SP--, PC<=stack[SP-1].
  - 6 ALU-I: Acc<=ALU(mode, Acc, operand); flags updated; PC+1.
  - 7 ALU-M: Acc<=ALU(mode, Acc, DR); flags updated; PC+1.
  - 8 ALU-W: DMEM[addr]<=ALU(mode, Acc, DR); flags updated; Acc unchanged; PC+1.
  - A STA: DMEM[addr]<=Acc; flags unchanged; PC+1.
  - 9, B-F: illegal; HALT with err 3.
- ALU modes (A=Acc, B=second operand); shift amount n = A mod DW:
  - 0 A+B, 1 A-B, 2 A, 3 B, 4 A&B, 5 A|B, 6 A^B, 7 B-A
  - 8 B+1, 9 B-1, A ROL B by n, B ROR B by n
  - C SHL, D SHR, E SAR, F 0-B
- Flags:
  - Z = (result==0).
  - S = result msb.
  - C: for ADD/INC it is carry-out. For SUB/RSUB/DEC/NEG it is no-borrow (1 when minuend >= subtrahend, unsigned). Preserved for all other modes.
  - O: two's-complement overflow for add/sub-class modes, 0 for all others.
- HALT: outputs hold; ld_ready=0; only rst exits.
- Reset mid-instruction aborts it; no memory write occurs on that edge.

Test Plan:
- DW=8, PAW=8, DAW=4, STACK_DEPTH=4, IW=16 throughout.
- Load 6005, 60FE, 1000 (ld_last on third) -> Acc=0x03, flags {Z,C,S,O}=0100, halted=1, error=0, pc_out=2, exactly 9 cycles from FETCH entry to halted.
- Load 6342, A003, 6300, 7303, 1000 -> after 6300 Z=1, Acc=0; final Acc=0x42, Z=0, DMEM[3]=0x42.
- Load 4004, 1000, 0000, 0000, 6801, 5000 -> CALL pushes 1, Acc=0x02, RET returns to 1, halted with pc_out=1, sp_out=0.
- Load single word 4000 -> four CALLs succeed (sp_out=4); fifth gives halted=1, error=1, err_code=1, pc_out=0. Separate run of 5000 -> err_code=2; separate run of F000 -> err_code=3.
- Load 6000, 3004, 1000, 0000, 3407, 6001, 1000, 6002 -> JCOND Z is taken to 4; JCOND not-Z falls through; Acc=0x01, halted at pc_out=6.
- Load with ld_valid toggling every other cycle -> contents still correct. Assert rst during EXECUTE of an A003 -> state=LOAD, DMEM[3] unchanged, all reset values observed.
